aip_stream_arb_mux: RTL and testbench
=====================================

AIP_STREAM_ARB_MUX -- requirements
Module: aip_stream_arb_mux

Interface
REQ-001 SHALL provide parameter DATAWIDTH, default 32: width of one channel's data word.
REQ-002 SHALL provide parameter SELBITS, default 2: channel index width; channel count NCH = 2**SELBITS.
REQ-003 SHALL provide parameter ARB_MODE, default 1: 0 = externally selected channel, 1 = round-robin arbitration.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port data_in, input, NCH*DATAWIDTH bits: channel i occupies bits [DATAWIDTH*i+DATAWIDTH-1 : DATAWIDTH*i].
REQ-007 SHALL have port valid_in, input, NCH bits: per-channel valid.
REQ-008 SHALL have port last_in, input, NCH bits: per-channel end-of-packet flag.
REQ-009 SHALL have port ready_out, output, NCH bits: per-channel ready back to the sources.
REQ-010 SHALL have port sel, input, SELBITS bits: channel select; used only when ARB_MODE=0.
REQ-011 SHALL have port data_out, output, DATAWIDTH bits: registered output word.
REQ-012 SHALL have port valid_out, output, 1 bit: output word valid.
REQ-013 SHALL have port last_out, output, 1 bit: registered end-of-packet flag.
REQ-014 SHALL have port grant_out, output, SELBITS bits: index of the channel that supplied the current data_out.
REQ-015 SHALL have port ready_in, input, 1 bit: downstream ready.

Function
REQ-016 A transfer SHALL occur on channel i when valid_in[i] and ready_out[i] are both 1 at a rising edge; the output transfer SHALL occur when valid_out and ready_in are both 1.
REQ-017 The output register SHALL load when load = (!valid_out || ready_in) and the granted channel is valid; it SHALL capture data, last and grant index.
REQ-018 When load=1 and the granted channel is not valid, valid_out SHALL go to 0; when load=0, all output registers SHALL hold.
REQ-019 ready_out[i] SHALL be combinational: ready_out[i] = load && (i == current grant); all other bits SHALL be 0.
REQ-020 Latency SHALL be exactly 1 cycle from input transfer to valid_out; sustained throughput SHALL be 1 beat per cycle with ready_in held at 1.
REQ-021 ARB_MODE=0: the grant SHALL equal sel, except while a packet is locked (REQ-023).
REQ-022 ARB_MODE=1: the grant SHALL be the first channel with valid_in set, searching upward modulo NCH from rr_ptr; rr_ptr SHALL update to (granted index + 1) mod NCH after each transfer carrying last_in=1.
REQ-023 Packet lock: after a transfer with last_in=0, lock SHALL be set and the grant SHALL stay frozen on that channel, ignoring sel and other valids, until a transfer with last_in=1 clears lock.
REQ-024 While locked, a low valid_in on the locked channel SHALL stall the block (valid_out goes 0 when drained) with no regrant.
REQ-025 Wrap-around: with rr_ptr = NCH-1, the search SHALL continue at channel 0 after channel NCH-1.
REQ-026 With no valid_in set, there SHALL be no grant change in ARB_MODE=1 and no transfer.
REQ-027 Single-beat packets (last_in=1 on the first beat) SHALL not set lock.

Reset
REQ-028 While rst=1: valid_out=0, last_out=0, data_out=0, grant_out=0, rr_ptr=0, lock=0, and ready_out=all zeros as a consequence.
REQ-029 Reset asserted mid-packet SHALL clear lock immediately; the partially sent packet SHALL NOT resume after reset.
REQ-030 The first grant after reset release SHALL search from channel 0.

Verification
REQ-031 ARB_MODE=1, NCH=4, all valid, all last=1, ready_in=1 -> grant_out sequence 0,1,2,3,0 on consecutive cycles; data_out matches each channel one cycle later.
REQ-032 ARB_MODE=1, ch1 sends a 3-beat packet (last on beat 3) while ch0/ch2 are valid -> three ch1 beats are contiguous, then grant goes to 2.
REQ-033 ARB_MODE=0, sel=2, data_in ch2=0xA5A5A5A5 valid, ready_in=0 for 3 cycles -> data_out holds 0xA5A5A5A5, ready_out=0, no loss; ready_in=1 -> a single transfer occurs.
REQ-034 ARB_MODE=0, sel switches 1->3 mid-packet on ch1 -> grant stays 1 until last, then moves to 3.
REQ-035 rst pulse asserted during a locked packet -> outputs 0 within the same cycle; after release, channel 0 is granted first if valid.
REQ-036 Only ch3 valid with rr_ptr=3, then only ch0 valid -> grants 3 then 0, confirming wrap-around.

Source files
------------

// File: rtl/aip_stream_arb_mux.sv
// aip_stream_arb_mux: N-channel stream arbiter/multiplexer with a single
// registered output stage and packet lock.
//   clk, rst          : clock, asynchronous active-high reset
//   data_in/valid_in/last_in : NCH source channels, channel i data at
//                       bits [DATAWIDTH*i +: DATAWIDTH]
//   ready_out         : per-channel ready back to sources (combinational)
//   sel               : channel select (external-select mode only)
//   data_out/valid_out/last_out/grant_out : registered output beat and the
//                       index of the channel that supplied it
//   ready_in          : downstream ready
// ARB_MODE 0 = grant follows sel, 1 = round-robin. A packet in flight keeps
// its grant until its last beat has transferred.
module aip_stream_arb_mux #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned SELBITS   = 2,
  parameter int unsigned ARB_MODE  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [(2**SELBITS)*DATAWIDTH-1:0] data_in,
  input  logic [(2**SELBITS)-1:0]           valid_in,
  input  logic [(2**SELBITS)-1:0]           last_in,
  output logic [(2**SELBITS)-1:0]           ready_out,
  input  logic [SELBITS-1:0]                sel,
  output logic [DATAWIDTH-1:0]              data_out,
  output logic                              valid_out,
  output logic                              last_out,
  output logic [SELBITS-1:0]                grant_out,
  input  logic                              ready_in
);

  localparam int unsigned NCH = 2 ** SELBITS;

  logic [SELBITS-1:0] rr_ptr;
  logic               lock;
  logic [SELBITS-1:0] lock_ch;

  logic [SELBITS-1:0] rr_pick;
  logic               rr_found;
  logic [SELBITS-1:0] rr_idx;
  logic [SELBITS-1:0] grant_c;
  logic               load_c;
  logic               grant_valid_c;

  // Round-robin search: first valid channel at or above rr_ptr. The index is
  // SELBITS wide so the addition wraps from NCH-1 back to 0 on its own.
  // With no valid channel the pick rests on rr_ptr, so nothing moves.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_ptr;
    rr_idx   = rr_ptr;
    for (int unsigned k = 0; k < NCH; k++) begin
      rr_idx = rr_ptr + SELBITS'(k);
      if (!rr_found && valid_in[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Current grant: a locked packet owns the mux, otherwise sel or round-robin.
  always_comb begin
    grant_c = sel;
    if (lock) begin
      grant_c = lock_ch;
    end else if (ARB_MODE != 0) begin
      grant_c = rr_pick;
    end
  end

  // Output stage can accept a beat when empty or being drained this cycle.
  assign load_c        = !valid_out || ready_in;
  assign grant_valid_c = valid_in[grant_c];

  // Only the granted channel sees ready; held low throughout reset.
  always_comb begin
    ready_out = '0;
    if (load_c && !rst) begin
      ready_out[grant_c] = 1'b1;
    end
  end

  // Output register plus arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      grant_out <= '0;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
    end else if (load_c) begin
      if (grant_valid_c) begin
        valid_out <= 1'b1;
        data_out  <= data_in[DATAWIDTH*grant_c +: DATAWIDTH];
        last_out  <= last_in[grant_c];
        grant_out <= grant_c;
        if (last_in[grant_c]) begin
          // Packet finished: release the mux and move priority past it.
          lock   <= 1'b0;
          rr_ptr <= grant_c + SELBITS'(1);
        end else begin
          lock    <= 1'b1;
          lock_ch <= grant_c;
        end
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aip_stream_arb_mux.sv
// Bench for aip_stream_arb_mux: one instance in external-select mode (m=0)
// and one in round-robin mode (m=1), checked every cycle against a
// transaction-level model plus directed literal expectations.
module tb_aip_stream_arb_mux;

  localparam int unsigned DW = 32;
  localparam int unsigned SB = 2;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] din [2];
  logic [NC-1:0]    vin [2];
  logic [NC-1:0]    lin [2];
  logic             rin [2];
  logic [SB-1:0]    sel;

  logic [NC-1:0] s_ready_out, r_ready_out;
  logic [DW-1:0] s_data_out,  r_data_out;
  logic          s_valid_out, r_valid_out;
  logic          s_last_out,  r_last_out;
  logic [SB-1:0] s_grant_out, r_grant_out;

  aip_stream_arb_mux #(.DATAWIDTH(DW), .SELBITS(SB), .ARB_MODE(0)) u_sel (
    .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(vin[0]), .last_in(lin[0]),
    .ready_out(s_ready_out), .sel(sel), .data_out(s_data_out),
    .valid_out(s_valid_out), .last_out(s_last_out), .grant_out(s_grant_out),
    .ready_in(rin[0])
  );

  aip_stream_arb_mux #(.DATAWIDTH(DW), .SELBITS(SB), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(vin[1]), .last_in(lin[1]),
    .ready_out(r_ready_out), .sel(sel), .data_out(r_data_out),
    .valid_out(r_valid_out), .last_out(r_last_out), .grant_out(r_grant_out),
    .ready_in(rin[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- model: one pending output beat per instance ----------------
  logic          ev  [2];
  logic          el  [2];
  logic [DW-1:0] ed  [2];
  logic [SB-1:0] eg  [2];
  logic [SB-1:0] ptr [2];
  logic          lk  [2];
  logic [SB-1:0] own [2];
  logic [SB-1:0] mg;

  // Which channel the rules say owns the output right now.
  function automatic logic [SB-1:0] mgrant(input int m);
    if (lk[m]) return own[m];
    if (m == 0) return sel;
    for (int k = 0; k < int'(NC); k++) begin
      int c;
      c = (int'(ptr[m]) + k) % int'(NC);
      if (vin[m][c]) return SB'(c);
    end
    return ptr[m];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        ev[m] = 1'b0; el[m] = 1'b0; ed[m] = '0; eg[m] = '0;
        ptr[m] = '0; lk[m] = 1'b0; own[m] = '0;
      end else if (!ev[m] || rin[m]) begin
        mg = mgrant(m);
        if (vin[m][mg]) begin
          ev[m] = 1'b1;
          ed[m] = din[m][DW*mg +: DW];
          el[m] = lin[m][mg];
          eg[m] = mg;
          if (lin[m][mg]) begin
            lk[m]  = 1'b0;
            ptr[m] = SB'((int'(mg) + 1) % int'(NC));
          end else begin
            lk[m]  = 1'b1;
            own[m] = mg;
          end
        end else begin
          ev[m] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [NC-1:0] er;
    for (int m = 0; m < 2; m++) begin
      er = '0;
      if ((!ev[m] || rin[m]) && !rst) er = NC'(1) << mgrant(m);
      if (m == 0) begin
        chk("m0 valid_out", 64'(s_valid_out), 64'(ev[0]));
        chk("m0 data_out",  64'(s_data_out),  64'(ed[0]));
        chk("m0 last_out",  64'(s_last_out),  64'(el[0]));
        chk("m0 grant_out", 64'(s_grant_out), 64'(eg[0]));
        chk("m0 ready_out", 64'(s_ready_out), 64'(er));
      end else begin
        chk("m1 valid_out", 64'(r_valid_out), 64'(ev[1]));
        chk("m1 data_out",  64'(r_data_out),  64'(ed[1]));
        chk("m1 last_out",  64'(r_last_out),  64'(el[1]));
        chk("m1 grant_out", 64'(r_grant_out), 64'(eg[1]));
        chk("m1 ready_out", 64'(r_ready_out), 64'(er));
      end
    end
  end

  // One clock; returns just after the falling edge so inputs change off-edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic setw(input int m, input int c, input logic [DW-1:0] w);
    din[m][DW*c +: DW] = w;
  endtask

  initial begin
    rst = 1'b1;
    sel = '0;
    for (int m = 0; m < 2; m++) begin
      din[m] = '0; vin[m] = '0; lin[m] = '0; rin[m] = 1'b1;
    end
    step();
    step();
    chk("reset valid", 64'(r_valid_out), 64'd0);
    chk("reset ready", 64'(r_ready_out), 64'd0);
    chk("reset grant", 64'(r_grant_out), 64'd0);
    rst = 1'b0;

    // Round-robin over four always-valid single-beat channels.
    for (int c = 0; c < 4; c++) setw(1, c, 32'h1000_0000 + DW'(c));
    vin[1] = 4'hF; lin[1] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr seq grant", 64'(r_grant_out), 64'(i % 4));
      chk("rr seq data",  64'(r_data_out),  64'(32'h1000_0000 + DW'(i % 4)));
      chk("rr seq valid", 64'(r_valid_out), 64'd1);
    end

    // Three-beat packet on ch1 stays contiguous, then ch2.
    vin[1] = 4'b0111; lin[1] = 4'b0101; setw(1, 1, 32'h2000_0001);
    step();
    chk("pkt b1 grant", 64'(r_grant_out), 64'd1);
    chk("pkt b1 last",  64'(r_last_out),  64'd0);
    setw(1, 1, 32'h2000_0002);
    step();
    chk("pkt b2 grant", 64'(r_grant_out), 64'd1);
    chk("pkt b2 data",  64'(r_data_out),  64'h2000_0002);
    lin[1] = 4'b0111; setw(1, 1, 32'h2000_0003);
    step();
    chk("pkt b3 grant", 64'(r_grant_out), 64'd1);
    chk("pkt b3 last",  64'(r_last_out),  64'd1);
    step();
    chk("pkt next grant", 64'(r_grant_out), 64'd2);
    chk("pkt next data",  64'(r_data_out),  64'h1000_0002);

    // Wrap: pointer now at 3, ch3 alone then ch0 alone.
    vin[1] = 4'b1000; lin[1] = 4'hF;
    step();
    chk("wrap grant3", 64'(r_grant_out), 64'd3);
    vin[1] = 4'b0001;
    step();
    chk("wrap grant0", 64'(r_grant_out), 64'd0);
    chk("wrap data0",  64'(r_data_out),  64'h1000_0000);

    // Idle: nothing valid, output drains, grant holds.
    vin[1] = 4'b0000;
    step();
    step();
    chk("idle valid", 64'(r_valid_out), 64'd0);
    chk("idle grant", 64'(r_grant_out), 64'd0);

    // Locked owner goes quiet: stall, no regrant to other valid channels.
    vin[1] = 4'b0010; lin[1] = 4'b0000; setw(1, 1, 32'h2000_0011);
    step();
    chk("stall start grant", 64'(r_grant_out), 64'd1);
    vin[1] = 4'b0101; lin[1] = 4'b0101;
    step();
    chk("stall valid", 64'(r_valid_out), 64'd0);
    chk("stall ready", 64'(r_ready_out), 64'b0010);
    step();
    chk("stall grant", 64'(r_grant_out), 64'd1);
    vin[1] = 4'b0111; lin[1] = 4'b0111; setw(1, 1, 32'h2000_0012);
    step();
    chk("stall end data", 64'(r_data_out), 64'h2000_0012);
    chk("stall end last", 64'(r_last_out), 64'd1);

    // Reset in the middle of a ch2 packet.
    vin[1] = 4'b0100; lin[1] = 4'b0000; setw(1, 2, 32'h2000_0022);
    step();
    chk("pre-rst grant", 64'(r_grant_out), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst valid", 64'(r_valid_out), 64'd0);
    chk("rst data",  64'(r_data_out),  64'd0);
    chk("rst grant", 64'(r_grant_out), 64'd0);
    chk("rst ready", 64'(r_ready_out), 64'd0);
    step();
    rst = 1'b0;
    vin[1] = 4'b0101; lin[1] = 4'b0101;
    step();
    chk("post-rst grant", 64'(r_grant_out), 64'd0);
    chk("post-rst data",  64'(r_data_out),  64'h1000_0000);
    vin[1] = 4'b0000;

    // External select with downstream backpressure.
    sel = 2'd2; setw(0, 2, 32'hA5A5_A5A5); vin[0] = 4'b0100; lin[0] = 4'b0100; rin[0] = 1'b0;
    step();
    chk("bp load data", 64'(s_data_out), 64'hA5A5_A5A5);
    setw(0, 2, 32'hB6B6_B6B6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp hold data",  64'(s_data_out),  64'hA5A5_A5A5);
      chk("bp hold valid", 64'(s_valid_out), 64'd1);
      chk("bp hold ready", 64'(s_ready_out), 64'd0);
    end
    rin[0] = 1'b1;
    step();
    chk("bp release data", 64'(s_data_out), 64'hB6B6_B6B6);
    vin[0] = 4'b0000;
    step();
    chk("bp drained", 64'(s_valid_out), 64'd0);

    // sel changes mid-packet; grant follows only after the last beat.
    sel = 2'd1; vin[0] = 4'b1010; lin[0] = 4'b1000;
    setw(0, 1, 32'h3000_0001); setw(0, 3, 32'h3000_0003);
    step();
    chk("sel b1 grant", 64'(s_grant_out), 64'd1);
    sel = 2'd3; setw(0, 1, 32'h3000_0002);
    step();
    chk("sel b2 grant", 64'(s_grant_out), 64'd1);
    chk("sel b2 data",  64'(s_data_out),  64'h3000_0002);
    lin[0] = 4'b1010; setw(0, 1, 32'h3000_0003);
    step();
    chk("sel b3 last", 64'(s_last_out), 64'd1);
    step();
    chk("sel moved grant", 64'(s_grant_out), 64'd3);

    // Single-beat packet leaves the mux free to follow sel.
    sel = 2'd0; vin[0] = 4'b0001; lin[0] = 4'b0001; setw(0, 0, 32'h3000_0000);
    step();
    chk("single grant0", 64'(s_grant_out), 64'd0);
    sel = 2'd2; vin[0] = 4'b0100; lin[0] = 4'b0100; setw(0, 2, 32'h3000_0022);
    step();
    chk("single grant2", 64'(s_grant_out), 64'd2);
    chk("single data2",  64'(s_data_out),  64'h3000_0022);
    vin[0] = 4'b0000;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
